// File: rtl/program_counter_ras.sv
// Fetch-stage PC generator with prioritised redirects,
// call/return prediction and a circular return-address stack.
module program_counter_ras #(
  parameter int                      WIDTH          = 32,
  parameter logic [WIDTH-1:0]        PC_INIT        = 32'h0000_3000,
  parameter int                      STEP           = 4,
  parameter int                      NUM_REDIRECT   = 3,
  parameter logic [NUM_REDIRECT-1:0] STALL_OVERRIDE = 3'b001,
  parameter int                      RAS_DEPTH      = 8
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            stall,
  input  logic [NUM_REDIRECT-1:0]         redirectValid,
  input  logic [NUM_REDIRECT*WIDTH-1:0]   redirectTarget,
  input  logic                            callEnable,
  input  logic [WIDTH-1:0]                callTarget,
  input  logic                            returnEnable,
  output logic [WIDTH-1:0]                pcValue,
  output logic [$clog2(RAS_DEPTH+1)-1:0]  rasCount,
  output logic                            rasOverflow,
  output logic                            rasUnderflow
);

  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = $clog2(RAS_DEPTH+1);
  localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);
  localparam logic [CW-1:0]    FULL   = CW'(RAS_DEPTH);

  logic [WIDTH-1:0]        pc_q, pc_d;
  logic [PW-1:0]           top_q, top_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic                    ovf_q, ovf_d;
  logic                    unf_q, unf_d;
  logic [WIDTH-1:0]        ras_q [RAS_DEPTH];

  logic [NUM_REDIRECT-1:0] eff;
  logic [WIDTH-1:0]        tgt;
  logic [WIDTH-1:0]        seq;
  logic [PW-1:0]           wptr;
  logic                    push;

  // Next-PC arbitration: redirect > return > call > sequential
  always_comb begin
    eff   = stall ? (redirectValid & STALL_OVERRIDE)
                  : redirectValid;
    tgt   = '0;
    for (int i = NUM_REDIRECT-1; i >= 0; i--) begin
      if (eff[i]) tgt = redirectTarget[i*WIDTH +: WIDTH];
    end
    seq   = pc_q + STEP_W;
    wptr  = top_q + PW'(1);
    pc_d  = pc_q;
    top_d = top_q;
    cnt_d = cnt_q;
    ovf_d = 1'b0;
    unf_d = 1'b0;
    push  = 1'b0;
    if (|eff) begin
      pc_d = tgt;
    end else if (stall) begin
      pc_d = pc_q;
    end else if (returnEnable) begin
      if (cnt_q == '0) begin
        pc_d  = seq;
        unf_d = 1'b1;
      end else begin
        pc_d  = ras_q[top_q];
        top_d = top_q - PW'(1);
        cnt_d = cnt_q - CW'(1);
      end
    end else if (callEnable) begin
      pc_d  = callTarget;
      push  = 1'b1;
      top_d = wptr;
      if (cnt_q == FULL) ovf_d = 1'b1;
      else               cnt_d = cnt_q + CW'(1);
    end else begin
      pc_d = seq;
    end
  end

  // PC, stack pointer, occupancy and event pulses
  always_ff @(posedge clock) begin
    if (reset) begin
      pc_q  <= PC_INIT - STEP_W;
      top_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      top_q <= top_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  // Stack storage; contents are meaningless after reset
  always_ff @(posedge clock) begin
    if (push && !reset) ras_q[wptr] <= seq;
  end

  assign pcValue      = pc_q;
  assign rasCount     = cnt_q;
  assign rasOverflow  = ovf_q;
  assign rasUnderflow = unf_q;

endmodule

// File: tb/tb_program_counter_ras.sv
// Scoreboard bench for program_counter_ras:
// stimulus queues expectations, monitor checks each edge.
module tb_program_counter_ras;

  logic        clock = 1'b0;
  logic        reset;
  logic        stall;
  logic [2:0]  redirectValid;
  logic [95:0] redirectTarget;
  logic        callEnable;
  logic [31:0] callTarget;
  logic        returnEnable;
  logic [31:0] pcValue;
  logic [3:0]  rasCount;
  logic        rasOverflow;
  logic        rasUnderflow;

  typedef struct {
    logic [31:0] pc;
    logic [3:0]  cnt;
    logic        ovf;
    logic        unf;
    string       nm;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  bit   done   = 0;

  program_counter_ras dut (
    .clock          (clock),
    .reset          (reset),
    .stall          (stall),
    .redirectValid  (redirectValid),
    .redirectTarget (redirectTarget),
    .callEnable     (callEnable),
    .callTarget     (callTarget),
    .returnEnable   (returnEnable),
    .pcValue        (pcValue),
    .rasCount       (rasCount),
    .rasOverflow    (rasOverflow),
    .rasUnderflow   (rasUnderflow)
  );

  always #5 clock = ~clock;

  task automatic set_tgt(input logic [31:0] t0,
                         input logic [31:0] t1,
                         input logic [31:0] t2);
    redirectTarget = {t2, t1, t0};
  endtask

  task automatic cyc(input logic rst, input logic stl,
                     input logic [2:0] rv, input logic call,
                     input logic ret, input logic [31:0] ct,
                     input logic [31:0] epc, input logic [3:0] ecnt,
                     input logic eovf, input logic eunf,
                     input string nm);
    exp_t e;
    @(negedge clock);
    reset         = rst;
    stall         = stl;
    redirectValid = rv;
    callEnable    = call;
    returnEnable  = ret;
    callTarget    = ct;
    e.pc  = epc;
    e.cnt = ecnt;
    e.ovf = eovf;
    e.unf = eunf;
    e.nm  = nm;
    exp_q.push_back(e);
  endtask

  task automatic cmp(input string nm, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, req);
    end
  endtask

  // Monitor: one expectation per clock edge
  initial begin
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        cmp({e.nm, ".pc"},  pcValue, e.pc);
        cmp({e.nm, ".cnt"}, 32'(rasCount), 32'(e.cnt));
        cmp({e.nm, ".ovf"}, 32'(rasOverflow), 32'(e.ovf));
        cmp({e.nm, ".unf"}, 32'(rasUnderflow), 32'(e.unf));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1; stall = 0; redirectValid = 0;
    callEnable = 0; returnEnable = 0; callTarget = 0;
    set_tgt(32'h8000, 32'h4000, 32'h5000);
    // reset and sequential fetch
    cyc(1,0,3'b000,0,0,0, 32'h2FFC,0,0,0,"rst0");
    cyc(1,0,3'b000,0,0,0, 32'h2FFC,0,0,0,"rst1");
    cyc(0,0,3'b000,0,0,0, 32'h3000,0,0,0,"seq0");
    cyc(0,0,3'b000,0,0,0, 32'h3004,0,0,0,"seq1");
    cyc(0,0,3'b000,0,0,0, 32'h3008,0,0,0,"seq2");
    // stall with and without overriding channel
    cyc(0,1,3'b010,0,0,0, 32'h3008,0,0,0,"stl0");
    cyc(0,1,3'b010,1,1,32'h9000, 32'h3008,0,0,0,"stl1");
    cyc(0,1,3'b011,0,0,0, 32'h8000,0,0,0,"stlovr");
    cyc(0,0,3'b110,0,0,0, 32'h4000,0,0,0,"redir");
    // nested call/return
    cyc(1,0,3'b000,0,0,0, 32'h2FFC,0,0,0,"rst2");
    cyc(0,0,3'b000,0,0,0, 32'h3000,0,0,0,"seq3");
    cyc(0,0,3'b000,1,0,32'h3100, 32'h3100,1,0,0,"call0");
    cyc(0,0,3'b000,1,0,32'h3200, 32'h3200,2,0,0,"call1");
    cyc(0,0,3'b000,0,1,0, 32'h3104,1,0,0,"ret0");
    cyc(0,0,3'b000,0,1,0, 32'h3004,0,0,0,"ret1");
    // nine calls: overflow on the last only
    for (int k = 1; k <= 9; k++) begin
      cyc(0,0,3'b000,1,0,32'h10000 + 32'(k)*32'h100,
          32'h10000 + 32'(k)*32'h100,
          (k > 8) ? 4'd8 : 4'(k), (k == 9), 0, "ovcall");
    end
    // eight LIFO returns: 0x10804 down to 0x10104
    for (int k = 8; k >= 1; k--) begin
      cyc(0,0,3'b000,0,1,0, 32'h10004 + 32'(k)*32'h100,
          4'(k-1), 0, 0, "lifo");
    end
    cyc(0,0,3'b000,0,1,0, 32'h10108,0,0,1,"undf");
    cyc(0,0,3'b000,0,0,0, 32'h1010C,0,0,0,"undf_clr");
    // call+return together, redirect+call together
    cyc(0,0,3'b000,1,0,32'h20000, 32'h20000,1,0,0,"callA");
    cyc(0,0,3'b000,1,1,32'h30000, 32'h10110,0,0,0,"callret");
    cyc(0,0,3'b000,1,0,32'h20000, 32'h20000,1,0,0,"callB");
    set_tgt(32'hFFFF_FFF8, 32'h4000, 32'h6000);
    cyc(0,0,3'b100,1,0,32'h30000, 32'h6000,1,0,0,"rdcall");
    cyc(0,0,3'b000,0,1,0, 32'h10114,0,0,0,"ret2");
    cyc(0,1,3'b000,1,0,32'h30000, 32'h10114,0,0,0,"stlcall");
    // address wrap
    cyc(0,0,3'b001,0,0,0, 32'hFFFF_FFF8,0,0,0,"wrap0");
    cyc(0,0,3'b000,0,0,0, 32'hFFFF_FFFC,0,0,0,"wrap1");
    cyc(0,0,3'b000,0,0,0, 32'h0000_0000,0,0,0,"wrap2");
    // reset during a call with three entries
    cyc(0,0,3'b000,1,0,32'h100, 32'h100,1,0,0,"c1");
    cyc(0,0,3'b000,1,0,32'h200, 32'h200,2,0,0,"c2");
    cyc(0,0,3'b000,1,0,32'h300, 32'h300,3,0,0,"c3");
    cyc(1,0,3'b000,1,0,32'h400, 32'h2FFC,0,0,0,"rstcall");
    cyc(0,0,3'b000,0,1,0, 32'h3000,0,0,1,"postrst");
    cyc(0,0,3'b000,0,0,0, 32'h3004,0,0,0,"tail");
    for (int n = 0; n < 4 && exp_q.size() > 0; n++) @(negedge clock);
    cmp("drain", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
